// File: rtl/fip_32_pkg.sv
// Shared definitions for the Q16.16 fixed-point 3x3 determinant datapath:
// number format, matrix type, FSM encoding and overflow helpers.
package fip_32_pkg;

    localparam int FRAC_BITS = 16;
    localparam int FIX_W     = 32;

    typedef logic signed [FIX_W-1:0] fix_t;

    // [row][col]; operands a..i map row-major onto [0][0]..[2][2]
    typedef fix_t [2:0][2:0] mat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_t;

    localparam logic [3:0] STEP_ACC_FIRST = 4'd6;
    localparam logic [3:0] STEP_LAST      = 4'd8;

    function automatic logic add_ovf(input fix_t x, input fix_t y, input fix_t s);
        return (x[FIX_W-1] == y[FIX_W-1]) && (s[FIX_W-1] != x[FIX_W-1]);
    endfunction

    function automatic logic sub_ovf(input fix_t x, input fix_t y, input fix_t d);
        return (x[FIX_W-1] != y[FIX_W-1]) && (d[FIX_W-1] != x[FIX_W-1]);
    endfunction

endpackage

// File: rtl/fip_32_mult.sv
// Combinational Q16.16 multiplier: full 64-bit product, arithmetic shift
// by FRAC_BITS (truncation toward -inf), wrapped 32-bit result plus overflow.
module fip_32_mult
    import fip_32_pkg::*;
(
    input  fix_t a,
    input  fix_t b,
    output fix_t p,
    output logic ovf
);

    logic signed [2*FIX_W-1:0] full;
    logic signed [2*FIX_W-1:0] scaled;

    // Sign-extended operands make the low 64 bits of the product exact.
    assign full   = {{FIX_W{a[FIX_W-1]}}, a} * {{FIX_W{b[FIX_W-1]}}, b};
    assign scaled = full >>> FRAC_BITS;

    // Result fits only if bits above the Q16.16 sign bit are all sign copies.
    assign ovf = (scaled[2*FIX_W-1:FIX_W-1] != {(FIX_W+1){scaled[FIX_W-1]}});
    assign p   = scaled[FIX_W-1:0];

endmodule

// File: rtl/fip_32_3b3_det_seq.sv
// Sequential Q16.16 3x3 determinant by cofactor expansion along row 0,
// using one shared multiplier over nine steps with a valid/ready handshake.
module fip_32_3b3_det_seq
    import fip_32_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_ready,
    input  mat_t i_array,
    output logic o_valid,
    input  logic i_ready,
    output fix_t o_det,
    output logic o_overflow,
    output logic o_busy
);

    logic [1:0] rst_meta;
    logic       rst_n;

    state_t     state_q, state_d;
    logic [3:0] step_q;
    mat_t       mat_q;
    fix_t       prod_q [6];
    fix_t       acc_q;
    logic       sticky_q;
    fix_t       det_q;
    logic       ovf_q;

    fix_t       op_a, op_b;
    fix_t       sub_x, sub_y, diff;
    fix_t       mult_p;
    logic       mult_ovf;
    fix_t       sum;
    logic       acc_step;
    logic       step_ovf;
    logic       accept;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_meta <= 2'b00;
        end else begin
            rst_meta <= {rst_meta[0], 1'b1};
        end
    end

    assign rst_n = rst_meta[1];

    assign accept   = (state_q == ST_IDLE) && i_valid;
    assign acc_step = (step_q >= STEP_ACC_FIRST);

    // Steps 0..5 form the six minor products; steps 6..8 weight each minor
    // difference by its row-0 coefficient.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        op_a  = '0;
        op_b  = '0;
        sub_x = '0;
        sub_y = '0;
        case (step_q)
            4'd0: begin op_a = mat_q[1][1]; op_b = mat_q[2][2]; end
            4'd1: begin op_a = mat_q[1][2]; op_b = mat_q[2][1]; end
            4'd2: begin op_a = mat_q[1][2]; op_b = mat_q[2][0]; end
            4'd3: begin op_a = mat_q[1][0]; op_b = mat_q[2][2]; end
            4'd4: begin op_a = mat_q[1][0]; op_b = mat_q[2][1]; end
            4'd5: begin op_a = mat_q[1][1]; op_b = mat_q[2][0]; end
            4'd6: begin op_a = mat_q[0][0]; sub_x = prod_q[0]; sub_y = prod_q[1]; end
            4'd7: begin op_a = mat_q[0][1]; sub_x = prod_q[2]; sub_y = prod_q[3]; end
            4'd8: begin op_a = mat_q[0][2]; sub_x = prod_q[4]; sub_y = prod_q[5]; end
            default: ;
        endcase
        diff = sub_x - sub_y;
        if (acc_step) begin
            op_b = diff;
        end
    end

    fip_32_mult u_mult (
        .a   (op_a),
        .b   (op_b),
        .p   (mult_p),
        .ovf (mult_ovf)
    );

    assign sum      = acc_q + mult_p;
    assign step_ovf = mult_ovf
                    | (acc_step & (sub_ovf(sub_x, sub_y, diff) | add_ovf(acc_q, mult_p, sum)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid)             state_d = ST_MUL;
            ST_MUL:  if (step_q == STEP_LAST) state_d = ST_DONE;
            ST_DONE: if (i_ready)             state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            det_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                step_q   <= '0;
                acc_q    <= '0;
                sticky_q <= 1'b0;
            end else if (state_q == ST_MUL) begin
                step_q   <= step_q + 4'd1;
                sticky_q <= sticky_q | step_ovf;
                if (acc_step) begin
                    acc_q <= sum;
                end
                if (step_q == STEP_LAST) begin
                    det_q <= sum;
                    ovf_q <= sticky_q | step_ovf;
                end
            end
        end
    end

    // NOTE: operand and product storage is left unreset; it is always written
    // before being read within an evaluation, so a reset would only cost area.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            mat_q <= i_array;
        end
        if ((state_q == ST_MUL) && !acc_step) begin
            prod_q[step_q[2:0]] <= mult_p;
        end
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_valid    = (state_q == ST_DONE);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_det      = det_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_fip_32_3b3_det_seq.sv
// Directed bench for fip_32_3b3_det_seq: reset, latency, known determinants,
// overflow sources, output hold under back-pressure and mid-run reset.
module tb_fip_32_3b3_det_seq;
    import fip_32_pkg::*;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic i_ready = 1'b1;
    mat_t i_array = '0;
    logic o_ready, o_valid, o_overflow, o_busy;
    fix_t o_det;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    fip_32_3b3_det_seq dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_array    (i_array),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_det      (o_det),
        .o_overflow (o_overflow),
        .o_busy     (o_busy)
    );

    function automatic fix_t q(input int v);
        return fix_t'(v <<< 16);
    endfunction

    function automatic mat_t mk(input fix_t a, input fix_t b, input fix_t c,
                                input fix_t d, input fix_t e, input fix_t f,
                                input fix_t g, input fix_t h, input fix_t i);
        mat_t m;
        m[0][0] = a; m[0][1] = b; m[0][2] = c;
        m[1][0] = d; m[1][1] = e; m[1][2] = f;
        m[2][0] = g; m[2][1] = h; m[2][2] = i;
        return m;
    endfunction

    // Drives one request from IDLE; lat = clock edges after the accept edge
    // until o_valid is seen (9 means o_valid in cycle 10).
    task automatic issue(input mat_t m, output int lat);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_array = m;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_array = {9{32'h7fff_ffff}};
        lat = 0;
        while (!o_valid && lat < 30) begin
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_ready, o_valid, o_busy, o_overflow} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 1000", {o_ready, o_valid, o_busy, o_overflow});
        end
        n_checks++;
        if (o_det !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_det: got %h expected 00000000", o_det);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_identity();
        int lat;
        issue(mk(q(1), 0, 0, 0, q(1), 0, 0, 0, q(1)), lat);
        n_checks++;
        if (lat !== 9) begin
            n_errors++;
            $display("FAIL identity_latency: got %0d expected 9", lat);
        end
        n_checks++;
        if ({o_det, o_overflow} !== {32'h0001_0000, 1'b0}) begin
            n_errors++;
            $display("FAIL identity_result: got det=%h ovf=%b expected det=00010000 ovf=0", o_det, o_overflow);
        end
        n_checks++;
        if ({o_ready, o_busy} !== 2'b01) begin
            n_errors++;
            $display("FAIL identity_done_flags: got ready=%b busy=%b expected 0 1", o_ready, o_busy);
        end
        @(negedge i_clk);
        n_checks++;
        if ({o_ready, o_valid, o_busy, o_det} !== {3'b100, 32'h0001_0000}) begin
            n_errors++;
            $display("FAIL identity_cycle11: got ready=%b valid=%b busy=%b det=%h expected 1 0 0 00010000",
                     o_ready, o_valid, o_busy, o_det);
        end
    endtask

    task automatic test_values();
        mat_t mats [8];
        fix_t dets [8];
        logic ovfs [8];
        int   lat;
        mats[0] = mk(q(2), 0, 0, 0, q(3), 0, 0, 0, q(4));                      dets[0] = 32'h0018_0000; ovfs[0] = 1'b0;
        mats[1] = mk(q(1), q(2), q(3), q(4), q(5), q(6), q(7), q(8), q(9));   dets[1] = 32'h0000_0000; ovfs[1] = 1'b0;
        mats[2] = mk(q(2), q(-1), q(1), q(1), q(3), q(2), 0, q(1), q(4));     dets[2] = 32'h0019_0000; ovfs[2] = 1'b0;
        mats[3] = mk(32'h8000, 0, 0, 0, 32'h8000, 0, 0, 0, 32'h8000);          dets[3] = 32'h0000_2000; ovfs[3] = 1'b0;
        mats[4] = mk(32'hfffe_8000, 0, 0, 0, q(2), 0, 0, 0, q(1));             dets[4] = 32'hfffd_0000; ovfs[4] = 1'b0;
        mats[5] = mk(q(256), 0, 0, 0, q(256), 0, 0, 0, q(256));                dets[5] = 32'h0000_0000; ovfs[5] = 1'b1;
        mats[6] = mk(0, 0, 0, 0, q(181), q(181), 0, q(-181), q(181));          dets[6] = 32'h0000_0000; ovfs[6] = 1'b1;
        mats[7] = mk(q(200), q(200), 0, 0, q(100), q(100), q(1), 0, q(1));     dets[7] = 32'h9c40_0000; ovfs[7] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            issue(mats[k], lat);
            n_checks++;
            if (lat !== 9) begin
                n_errors++;
                $display("FAIL vec%0d_latency: got %0d expected 9", k, lat);
            end
            n_checks++;
            if ({o_det, o_overflow} !== {dets[k], ovfs[k]}) begin
                n_errors++;
                $display("FAIL vec%0d_result: got det=%h ovf=%b expected det=%h ovf=%b",
                         k, o_det, o_overflow, dets[k], ovfs[k]);
            end
            @(negedge i_clk);
            n_checks++;
            if (o_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL vec%0d_return_idle: got ready=%b expected 1", k, o_ready);
            end
        end
    endtask

    task automatic test_ready_hold();
        int lat;
        i_ready = 1'b0;
        issue(mk(q(2), 0, 0, 0, q(3), 0, 0, 0, q(4)), lat);
        n_checks++;
        if (lat !== 9) begin
            n_errors++;
            $display("FAIL hold_latency: got %0d expected 9", lat);
        end
        i_valid = 1'b1;
        i_array = mk(q(1), 0, 0, 0, q(1), 0, 0, 0, q(1));
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({o_valid, o_ready, o_overflow, o_det} !== {3'b100, 32'h0018_0000}) begin
                n_errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b ovf=%b det=%h expected 1 0 0 00180000",
                         k, o_valid, o_ready, o_overflow, o_det);
            end
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if ({o_ready, o_busy, o_valid} !== 3'b100) begin
            n_errors++;
            $display("FAIL hold_no_accept_on_release: got ready=%b busy=%b valid=%b expected 1 0 0",
                     o_ready, o_busy, o_valid);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_second_accept: got busy=%b expected 1", o_busy);
        end
        lat = 0;
        while (!o_valid && lat < 30) begin
            @(negedge i_clk);
            lat++;
        end
        n_checks++;
        if ({lat, o_det} !== {32'd9, 32'h0001_0000}) begin
            n_errors++;
            $display("FAIL hold_second_result: got lat=%0d det=%h expected 9 00010000", lat, o_det);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_midrun();
        int lat;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_array = mk(q(2), 0, 0, 0, q(3), 0, 0, 0, q(4));
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_busy, o_ready, o_overflow, o_det} !== {4'b0010, 32'h0}) begin
            n_errors++;
            $display("FAIL midrun_reset_outputs: got valid=%b busy=%b ready=%b ovf=%b det=%h expected 0 0 1 0 00000000",
                     o_valid, o_busy, o_ready, o_overflow, o_det);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (12) @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL midrun_aborted: got valid=%b busy=%b expected 0 0", o_valid, o_busy);
        end
        issue(mk(q(2), q(-1), q(1), q(1), q(3), q(2), 0, q(1), q(4)), lat);
        n_checks++;
        if ({lat, o_det, o_overflow} !== {32'd9, 32'h0019_0000, 1'b0}) begin
            n_errors++;
            $display("FAIL midrun_recovery: got lat=%0d det=%h ovf=%b expected 9 00190000 0", lat, o_det, o_overflow);
        end
        @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_values();
        test_ready_hold();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
